cyc_24_pucch1_despread: RTL and testbench

//  Receive-side PUCCH format 1 block-wise OCC despreader; inverse of the Tx spreading stage.
//  - Accepts nSF per-symbol complex values (base sequence already removed) for one hop.
//  - Multiplies each value by conj(wi(m)) = exp(-j*2*pi*phi(m)/24) and sums over m = 0..nSF-1.
//  - Emits one despread complex value per hop to the PUCCH1 detector.

---
 rtl/pucch_pkg.sv | 74 +++++++
 rtl/pucch1_occ_phase_gen.sv | 67 ++++++
 rtl/cyc_24_pucch1_despread.sv | 164 ++++++++++++++++
 tb/tb_cyc_24_pucch1_despread.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pucch_pkg.sv
// ----------------------------------------------------------------------------
// pucch_pkg
// Shared constants and helpers for the PUCCH format 1 block-wise OCC
// spreading/despreading paths.
//  - phase_t        : phase in 1/24 turn (0..23)
//  - state_t        : despreader FSM states
//  - nsf_supported  : spreading factors the OCC path can handle
//  - occ_step       : per-symbol phase step A(nSF) for the DFT-based OCC
//  - occ4_phase     : nSF=4 OCC table (phases 0 or 12)
//  - tw_cos/tw_sin  : Q2.14 twiddles for phase index k = phi/4
// ----------------------------------------------------------------------------
package pucch_pkg;

  typedef logic [4:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int TW_W = 16;  // twiddle table width, Q2.14

  function automatic logic nsf_supported(input logic [2:0] nsf);
    case (nsf)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd6: nsf_supported = 1'b1;
      default:                      nsf_supported = 1'b0;
    endcase
  endfunction

  // Step A = 24/nSF; nSF=4 uses the table instead, so it returns 0 here.
  function automatic phase_t occ_step(input logic [2:0] nsf);
    case (nsf)
      3'd1:    occ_step = 5'd24;
      3'd2:    occ_step = 5'd12;
      3'd3:    occ_step = 5'd8;
      3'd6:    occ_step = 5'd4;
      default: occ_step = 5'd0;
    endcase
  endfunction

  // Bit m of a row set means phase 12 (i.e. -1) for symbol m.
  function automatic phase_t occ4_phase(input logic [1:0] occi, input logic [1:0] m);
    logic [3:0] row;
    case (occi)
      2'd0:    row = 4'b0000;
      2'd1:    row = 4'b1010;
      2'd2:    row = 4'b1100;
      default: row = 4'b0110;
    endcase
    occ4_phase = row[m] ? 5'd12 : 5'd0;
  endfunction

  function automatic logic signed [TW_W-1:0] tw_cos(input logic [2:0] k);
    case (k)
      3'd0:    tw_cos = 16'sd16384;
      3'd1:    tw_cos = 16'sd8192;
      3'd2:    tw_cos = -16'sd8192;
      3'd3:    tw_cos = -16'sd16384;
      3'd4:    tw_cos = -16'sd8192;
      3'd5:    tw_cos = 16'sd8192;
      default: tw_cos = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] tw_sin(input logic [2:0] k);
    case (k)
      3'd1, 3'd2: tw_sin = 16'sd14189;
      3'd4, 3'd5: tw_sin = -16'sd14189;
      default:    tw_sin = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/pucch1_occ_phase_gen.sv
// ----------------------------------------------------------------------------
// pucch1_occ_phase_gen
// OCC phase sequencer for one PUCCH format 1 hop. Shared by Tx and Rx paths.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  i_start    latch i_nsf/i_occi and restart at m=0 (only when o_ok)
//  i_nsf      spreading factor
//  i_occi     OCC index
//  i_adv      advance to the next symbol
//  o_phi      phase of the current symbol m, 1/24 turn
//  o_last     current symbol is m = nSF-1
//  o_ok       i_nsf/i_occi form a supported combination (combinational)
// ----------------------------------------------------------------------------
module pucch1_occ_phase_gen
  import pucch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [2:0] i_nsf,
  input  logic [2:0] i_occi,
  input  logic       i_adv,
  output phase_t     o_phi,
  output logic       o_last,
  output logic       o_ok
);

  logic [2:0] nsf_q;
  logic [2:0] occi_q;
  logic [2:0] m_q;
  phase_t     phi_q;
  phase_t     phi_d;
  logic [7:0] step;
  logic [7:0] sum;

  assign o_ok = nsf_supported(i_nsf) && (i_occi < i_nsf);

  // occi < nSF guarantees occi*A < 24, so one conditional subtract is a full mod 24.
  always_comb begin
    step  = 8'(occi_q) * 8'(occ_step(nsf_q));
    sum   = 8'(phi_q) + step;
    phi_d = (sum >= 8'd24) ? phase_t'(sum - 8'd24) : phase_t'(sum);
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nsf_q  <= '0;
      occi_q <= '0;
      m_q    <= '0;
      phi_q  <= '0;
    end else if (i_start && o_ok) begin
      nsf_q  <= i_nsf;
      occi_q <= i_occi;
      m_q    <= '0;
      phi_q  <= '0;
    end else if (i_adv) begin
      m_q    <= m_q + 3'd1;
      phi_q  <= phi_d;
    end
  end

  assign o_phi  = (nsf_q == 3'd4) ? occ4_phase(occi_q[1:0], m_q[1:0]) : phi_q;
  assign o_last = (m_q == nsf_q - 3'd1);

endmodule

// File: rtl/cyc_24_pucch1_despread.sv
// ----------------------------------------------------------------------------
// cyc_24_pucch1_despread
// PUCCH format 1 block-wise OCC despreader: multiplies each of nSF symbols by
// conj(w(m)) and sums them into one complex result per hop.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  i_start           start a hop (latches i_nSF/i_occi); aborts any hop in flight
//  i_nSF, i_occi     spreading factor and OCC index
//  i_valid, i_re/im  input sample; accepted when i_valid & o_ready & ~i_start
//  o_ready           ready for a sample
//  o_valid           1-cycle pulse, o_re/o_im hold the hop result
//  o_re, o_im        despread sum (Q.14 scale, not rounded), held until next o_valid
//  o_err             1-cycle pulse: start rejected
// Pipeline: stage 1 registers the complex product, stage 2 accumulates; the
// result appears 2 cycles after the last accepted sample.
// ----------------------------------------------------------------------------
module cyc_24_pucch1_despread
  import pucch_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,   // must be >= TW_W
  parameter int AW = DW + CW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [2:0]           i_nSF,
  input  logic [2:0]           i_occi,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic signed [AW-1:0] o_re,
  output logic signed [AW-1:0] o_im,
  output logic                 o_err
);

  localparam int PW = DW + CW + 1;  // full-precision complex product width

  state_t               state_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 err_q;
  logic signed [AW-1:0] re_q, im_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic signed [PW-1:0] p1_re_q, p1_im_q;
  logic                 p1_vld_q;

  phase_t               phi;
  logic                 last;
  logic                 ok;
  logic                 accept;
  logic [2:0]           tw_k;
  logic signed [CW-1:0] c_coef, s_coef;
  logic signed [DW+CW-1:0] xr_c, xi_s, xi_c, xr_s;
  logic signed [PW-1:0] prod_re_d, prod_im_d;
  logic signed [AW-1:0] sum_re_d, sum_im_d;

  // A start always wins over a sample presented in the same cycle.
  assign accept = i_valid && ready_q && !i_start;

  pucch1_occ_phase_gen u_phase (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_nsf  (i_nSF),
    .i_occi (i_occi),
    .i_adv  (accept),
    .o_phi  (phi),
    .o_last (last),
    .o_ok   (ok)
  );

  // phi is always a multiple of 4, so phi/4 selects one of 6 twiddles.
  assign tw_k   = 3'(phi / 5'd4);
  assign c_coef = CW'(tw_cos(tw_k));
  assign s_coef = CW'(tw_sin(tw_k));

  // x * conj(w): re = xr*c + xi*s, im = xi*c - xr*s
  assign xr_c      = i_re * c_coef;
  assign xi_s      = i_im * s_coef;
  assign xi_c      = i_im * c_coef;
  assign xr_s      = i_re * s_coef;
  assign prod_re_d = PW'(xr_c) + PW'(xi_s);
  assign prod_im_d = PW'(xi_c) - PW'(xr_s);

  assign sum_re_d  = acc_re_q + AW'(p1_re_q);
  assign sum_im_d  = acc_im_q + AW'(p1_im_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      p1_re_q  <= '0;
      p1_im_q  <= '0;
      p1_vld_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (i_start) begin
        // Start (or abort): flush the pipeline and clear the accumulator.
        p1_vld_q <= 1'b0;
        acc_re_q <= '0;
        acc_im_q <= '0;
        if (ok) begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            p1_vld_q <= 1'b0;
          end
          ST_RUN: begin
            if (p1_vld_q) begin
              acc_re_q <= sum_re_d;
              acc_im_q <= sum_im_d;
            end
            p1_vld_q <= accept;
            if (accept) begin
              p1_re_q <= prod_re_d;
              p1_im_q <= prod_im_d;
              if (last) begin
                ready_q <= 1'b0;
                state_q <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            // Stage 1 holds the last product; fold it in straight to the output.
            p1_vld_q <= 1'b0;
            re_q     <= sum_re_d;
            im_q     <= sum_im_d;
            valid_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
          default: begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            p1_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_re    = re_q;
  assign o_im    = im_q;

endmodule

// File: tb/tb_cyc_24_pucch1_despread.sv
// ----------------------------------------------------------------------------
// tb_cyc_24_pucch1_despread
// Directed vectors with hand-computed results plus a few model-checked hops.
// Drivers push expected results (value and due cycle) into queues; a monitor
// on the falling edge pops and compares whenever o_valid or o_err is seen.
// ----------------------------------------------------------------------------
module tb_cyc_24_pucch1_despread;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = DW + CW + 3;

  logic                 clk;
  logic                 rst;
  logic                 i_start;
  logic [2:0]           i_nSF;
  logic [2:0]           i_occi;
  logic                 i_valid;
  logic signed [DW-1:0] i_re, i_im;
  logic                 o_ready;
  logic                 o_valid;
  logic signed [AW-1:0] o_re, o_im;
  logic                 o_err;

  cyc_24_pucch1_despread #(.DW(DW), .CW(CW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_nSF  (i_nSF),
    .i_occi (i_occi),
    .i_valid(i_valid),
    .i_re   (i_re),
    .i_im   (i_im),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_re   (o_re),
    .o_im   (o_im),
    .o_err  (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    int     due;
  } exp_t;

  exp_t sb_q[$];
  int   err_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compare results and error pulses against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected o_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("o_re", longint'(o_re), e.re);
          check("o_im", longint'(o_im), e.im);
          check("o_valid cycle", cyc, e.due);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        check("missing o_valid by cycle", cyc, e.due);
      end
      if (o_err) begin
        if (err_q.size() == 0) check("unexpected o_err", 1, 0);
        else                   check("o_err cycle", cyc, err_q.pop_front());
      end else if (err_q.size() != 0 && err_q[0] < cyc) begin
        check("missing o_err by cycle", cyc, err_q.pop_front());
      end
    end
  end

  // Reference model, written directly from the phase/twiddle definitions.
  function automatic int model_phi(input int nsf, input int occi, input int m);
    int tbl4[4][4];
    tbl4 = '{'{0, 0, 0, 0}, '{0, 12, 0, 12}, '{0, 0, 12, 12}, '{0, 12, 12, 0}};
    if (nsf == 4) return tbl4[occi][m];
    return (m * occi * (24 / nsf)) % 24;
  endfunction

  function automatic void model_hop(input int nsf, input int occi,
                                    input int xr[7], input int xi[7],
                                    output longint er, output longint ei);
    longint cos_t[6];
    longint sin_t[6];
    cos_t = '{16384, 8192, -8192, -16384, -8192, 8192};
    sin_t = '{0, 14189, 14189, 0, -14189, -14189};
    er = 0;
    ei = 0;
    for (int m = 0; m < nsf; m++) begin
      int k;
      k  = model_phi(nsf, occi, m) / 4;
      er += longint'(xr[m]) * cos_t[k] + longint'(xi[m]) * sin_t[k];
      ei += longint'(xi[m]) * cos_t[k] - longint'(xr[m]) * sin_t[k];
    end
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic do_start(input int nsf, input int occi, input bit with_valid, input bit exp_err);
    i_start = 1'b1;
    i_nSF   = 3'(nsf);
    i_occi  = 3'(occi);
    i_valid = with_valid;
    i_re    = 16'sd5555;
    i_im    = -16'sd777;
    if (exp_err) err_q.push_back(cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic send(input int re, input int im, input int gap,
                      input bit push, input longint er, input longint ei);
    int t;
    repeat (gap) @(negedge clk);
    t = 0;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      check("o_ready timeout", 0, 1);
      return;
    end
    i_valid = 1'b1;
    i_re    = 16'(re);
    i_im    = 16'(im);
    if (push) begin
      exp_t e;
      e.re  = er;
      e.im  = ei;
      e.due = cyc + 2;
      sb_q.push_back(e);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic hop(input int nsf, input int occi, input int xr[7], input int xi[7],
                     input longint er, input longint ei, input bit rand_gap);
    do_start(nsf, occi, 1'b0, 1'b0);
    for (int m = 0; m < nsf; m++)
      send(xr[m], xi[m], rand_gap ? int'($urandom_range(0, 3)) : 0, m == nsf - 1, er, ei);
    repeat (3) @(negedge clk);
  endtask

  int     xr[7];
  int     xi[7];
  longint er, ei;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    i_start = 1'b0;
    i_nSF   = '0;
    i_occi  = '0;
    i_valid = 1'b0;
    i_re    = '0;
    i_im    = '0;
    #1 rst = 1'b1;
    #2;
    check("reset o_ready", o_ready, 0);
    check("reset o_valid", o_valid, 0);
    check("reset o_err",   o_err,   0);
    check("reset o_re",    longint'(o_re), 0);
    check("reset o_im",    longint'(o_im), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. nSF=2 occi=1: phases 0,12
    xr = '{1000, -1000, 0, 0, 0, 0, 0};  xi = '{default: 0};
    hop(2, 1, xr, xi, 64'sd32768000, 0, 1'b0);

    // 2. nSF=3: occi=1 cancels exactly, occi=0 sums
    xr = '{100, 100, 100, 0, 0, 0, 0};
    hop(3, 1, xr, xi, 0, 0, 1'b0);
    hop(3, 0, xr, xi, 64'sd4915200, 0, 1'b0);

    // 3. nSF=4 table rows 2 and 3
    xr = '{1, 1, -1, -1, 0, 0, 0};
    hop(4, 2, xr, xi, 64'sd65536, 0, 1'b0);
    hop(4, 3, xr, xi, 0, 0, 1'b0);

    // 4. nSF=6 occi=1, (0,100) at m=1: phase 4, k=1
    xr = '{default: 0};  xi = '{0, 100, 0, 0, 0, 0, 0};
    hop(6, 1, xr, xi, 64'sd1418900, 64'sd819200, 1'b0);

    // 5. Rejected starts and abort
    do_start(5, 0, 1'b0, 1'b1);
    check("o_ready after nSF=5", o_ready, 0);
    @(negedge clk);
    check("o_ready stays 0", o_ready, 0);
    do_start(2, 2, 1'b0, 1'b1);
    check("o_ready after occi>=nSF", o_ready, 0);
    repeat (2) @(negedge clk);
    do_start(3, 0, 1'b0, 1'b0);
    send(3000, 3000, 0, 1'b0, 0, 0);
    // New start with a sample on the same cycle: the sample must be ignored.
    do_start(2, 1, 1'b1, 1'b0);
    send(1000, 0, 0, 1'b0, 0, 0);
    send(-1000, 0, 0, 1'b1, 64'sd32768000, 0);
    repeat (3) @(negedge clk);

    // 6. Model-checked hops with random valid gaps
    xr = '{1200, -3400, 567, 8900, -1011, 2222, 0};
    xi = '{-450, 780, -9100, 33, 4096, -2048, 0};
    model_hop(6, 5, xr, xi, er, ei);  hop(6, 5, xr, xi, er, ei, 1'b1);
    model_hop(6, 3, xr, xi, er, ei);  hop(6, 3, xr, xi, er, ei, 1'b1);
    model_hop(4, 1, xr, xi, er, ei);  hop(4, 1, xr, xi, er, ei, 1'b1);
    model_hop(3, 2, xr, xi, er, ei);  hop(3, 2, xr, xi, er, ei, 1'b1);
    model_hop(1, 0, xr, xi, er, ei);  hop(1, 0, xr, xi, er, ei, 1'b1);
    xr = '{-32768, 32767, -32768, 32767, -32768, 32767, 0};
    xi = '{32767, 32767, -32768, -32768, 32767, 32767, 0};
    model_hop(6, 2, xr, xi, er, ei);  hop(6, 2, xr, xi, er, ei, 1'b1);

    // Reset mid-hop: outputs clear at once and the partial hop never completes.
    do_start(3, 1, 1'b0, 1'b0);
    send(500, 500, 0, 1'b0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("mid rst o_ready", o_ready, 0);
    check("mid rst o_valid", o_valid, 0);
    check("mid rst o_re",    longint'(o_re), 0);
    check("mid rst o_im",    longint'(o_im), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("o_ready after rst release", o_ready, 0);
    xr = '{700, -300, 0, 0, 0, 0, 0};  xi = '{-50, 90, 0, 0, 0, 0, 0};
    model_hop(2, 1, xr, xi, er, ei);  hop(2, 1, xr, xi, er, ei, 1'b1);

    repeat (10) @(negedge clk);
    check("pending results", sb_q.size(), 0);
    check("pending errors",  err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
